// File: rtl/tx_pkg.sv
// Shared TX constants: 4-ASK levels in 1s17, PRBS polynomial geometry and the Gray map.
// The pulse-shaping filter imports the same levels so both ends agree on full scale.
package tx_pkg;

    localparam int LFSR_WIDTH = 15;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED_DEFAULT = 15'h0001;

    localparam logic signed [17:0] LVL_OUTER = 18'sd98304;
    localparam logic signed [17:0] LVL_INNER = 18'sd32768;

    // Gray order keeps adjacent levels one bit apart: 00, 01, 11, 10 from low to high.
    function automatic logic signed [17:0] map_4ask(
        input logic [1:0]        bits,
        input logic signed [17:0] outer = LVL_OUTER,
        input logic signed [17:0] inner = LVL_INNER
    );
        logic signed [17:0] level;
        level = '0;
        case (bits)
            2'b00:   level = -outer;
            2'b01:   level = -inner;
            2'b11:   level = inner;
            default: level = outer;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/tx_symbol_upsampler_prbs_lfsr.sv
// Fibonacci LFSR for x^15+x^14+1 that consumes two bits per step2 pulse.
// bits shows the pair the next step2 will shift in, oldest bit in bits[1].
module prbs_lfsr
    import tx_pkg::*;
#(
    parameter int                WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step2,
    output logic [1:0] bits
);

    // An all-zero register would lock up, so a zero seed falls back to 1.
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    logic [WIDTH-1:0] lfsr;

    // Second feedback bit uses the taps as they sit after the first shift.
    assign bits = {lfsr[WIDTH-1] ^ lfsr[WIDTH-2], lfsr[WIDTH-2] ^ lfsr[WIDTH-3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else if (step2) begin
            lfsr <= {lfsr[WIDTH-3:0], bits};
        end
    end

endmodule

// File: rtl/tx_symbol_upsampler.sv
// PRBS -> Gray 4-ASK -> zero-stuffing to the sample rate, feeding the TX filter's x_in.
// One level per symbol followed by UPSAMPLE-1 exact zeros; run=0 idles at phase 0.
module tx_symbol_upsampler #(
    parameter int                 UPSAMPLE  = 4,
    parameter logic [14:0]        SEED      = 15'h0001,
    parameter logic signed [17:0] LVL_OUTER = tx_pkg::LVL_OUTER,
    parameter logic signed [17:0] LVL_INNER = tx_pkg::LVL_INNER
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        samp_en,
    input  logic                        run,
    output logic signed [17:0]          x_out,
    output logic                        sym_strobe,
    output logic [1:0]                  sym_bits,
    output logic [$clog2(UPSAMPLE)-1:0] phase
);
    import tx_pkg::map_4ask;
    import tx_pkg::LFSR_WIDTH;

    localparam int PW = $clog2(UPSAMPLE);
    localparam logic [PW-1:0] PHASE_LAST = PW'(UPSAMPLE - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    logic       step2;
    logic [1:0] bits;

    assign step2 = samp_en && run && (phase == '0);

    prbs_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED)
    ) u_prbs (
        .clk   (clk),
        .reset (reset),
        .step2 (step2),
        .bits  (bits)
    );

    // Leaving run drops the rest of the stuffed zeros; resuming starts a fresh symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out      <= '0;
            sym_strobe <= 1'b0;
            sym_bits   <= '0;
            phase      <= '0;
        end else if (samp_en && run) begin
            if (phase == '0) begin
                x_out      <= map_4ask(bits, LVL_OUTER, LVL_INNER);
                sym_bits   <= bits;
                sym_strobe <= 1'b1;
                phase      <= PHASE_ONE;
            end else begin
                x_out      <= '0;
                sym_strobe <= 1'b0;
                phase      <= (phase == PHASE_LAST) ? '0 : phase + PHASE_ONE;
            end
        end else if (samp_en) begin
            x_out      <= '0;
            sym_strobe <= 1'b0;
            phase      <= '0;
        end else begin
            sym_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// Bench for tx_symbol_upsampler: PRBS recurrence model, zero-stuffing rules, pause and reset.
// A second instance with SEED=0 must behave exactly like SEED=1.
module tb_tx_symbol_upsampler;
    localparam int U = 4;

    logic clk = 1'b0;
    logic reset, samp_en, run;
    logic signed [17:0] x_a, x_b;
    logic strobe_a, strobe_b;
    logic [1:0] bits_a, bits_b;
    logic [1:0] phase_a, phase_b;

    int n_cmp = 0;
    int n_bad = 0;

    bit hist[$];
    bit obs[$];
    int pos;
    logic signed [17:0] m_x;
    logic m_strobe;
    logic [1:0] m_bits;

    tx_symbol_upsampler #(.UPSAMPLE(U), .SEED(15'h0001)) u_dut (
        .clk(clk), .reset(reset), .samp_en(samp_en), .run(run),
        .x_out(x_a), .sym_strobe(strobe_a), .sym_bits(bits_a), .phase(phase_a));

    tx_symbol_upsampler #(.UPSAMPLE(U), .SEED(15'h0000)) u_dut0 (
        .clk(clk), .reset(reset), .samp_en(samp_en), .run(run),
        .x_out(x_b), .sym_strobe(strobe_b), .sym_bits(bits_b), .phase(phase_b));

    always #5 clk = ~clk;

    function automatic logic signed [17:0] level_of(logic [1:0] b);
        case (b)
            2'b00:   return -18'sd98304;
            2'b01:   return -18'sd32768;
            2'b11:   return 18'sd32768;
            default: return 18'sd98304;
        endcase
    endfunction

    // Bit history: newest last; register bit k corresponds to the bit k+1 steps old.
    function automatic void model_reset(logic [14:0] seed);
        hist.delete();
        for (int k = 14; k >= 0; k--) hist.push_back(seed[k]);
        pos = 0; m_x = '0; m_strobe = 1'b0; m_bits = '0;
    endfunction

    function automatic bit next_bit();
        bit nb;
        nb = hist[$-14] ^ hist[$-13];
        hist.push_back(nb);
        return nb;
    endfunction

    function automatic logic [14:0] model_lfsr();
        logic [14:0] v;
        for (int k = 0; k < 15; k++) v[k] = hist[$-k];
        return v;
    endfunction

    function automatic void model_step(bit en, bit r);
        bit b1, b2;
        m_strobe = 1'b0;
        if (en && r) begin
            if (pos == 0) begin
                b1 = next_bit();
                b2 = next_bit();
                m_bits = {b1, b2};
                m_x = level_of(m_bits);
                m_strobe = 1'b1;
            end else begin
                m_x = '0;
            end
            pos = (pos + 1) % U;
        end else if (en) begin
            m_x = '0;
            pos = 0;
        end
    endfunction

    task automatic cyc(bit en, bit r);
        samp_en = en;
        run = r;
        @(posedge clk);
        model_step(en, r);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; samp_en = 1'b1; run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (x_a !== 18'sd0) begin n_bad++; $display("FAIL reset_x got=%0d exp=0", x_a); end
        n_cmp++; if (strobe_a !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%0b exp=0", strobe_a); end
        n_cmp++; if (bits_a !== 2'b00 || phase_a !== 2'd0) begin n_bad++; $display("FAIL reset_bits_phase got=%0b/%0d exp=0/0", bits_a, phase_a); end
        n_cmp++; if (u_dut.u_prbs.lfsr !== 15'h0001) begin n_bad++; $display("FAIL reset_lfsr got=%h exp=0001", u_dut.u_prbs.lfsr); end
        #3 reset = 1'b0;
        model_reset(15'h0001);
    endtask

    task automatic test_prbs_start(string tag);
        for (int i = 0; i < 8 * U; i++) begin
            cyc(1'b1, 1'b1);
            n_cmp++; if (x_a !== m_x) begin n_bad++; $display("FAIL %s_x cyc=%0d got=%0d exp=%0d", tag, i, x_a, m_x); end
            n_cmp++; if (strobe_a !== m_strobe) begin n_bad++; $display("FAIL %s_strobe cyc=%0d got=%0b exp=%0b", tag, i, strobe_a, m_strobe); end
            n_cmp++; if (bits_a !== m_bits) begin n_bad++; $display("FAIL %s_bits cyc=%0d got=%0b exp=%0b", tag, i, bits_a, m_bits); end
            n_cmp++; if (phase_a !== 2'(pos)) begin n_bad++; $display("FAIL %s_phase cyc=%0d got=%0d exp=%0d", tag, i, phase_a, pos); end
            if (i == 6 * U - 1) begin
                n_cmp++; if (u_dut.u_prbs.lfsr !== 15'h1000) begin n_bad++; $display("FAIL %s_lfsr_sym6 got=%h exp=1000", tag, u_dut.u_prbs.lfsr); end
            end
            if (i == 6 * U) begin
                n_cmp++; if (x_a !== -18'sd32768) begin n_bad++; $display("FAIL %s_sym7 got=%0d exp=-32768", tag, x_a); end
            end
        end
    endtask

    task automatic test_sparse_enable();
        for (int i = 0; i < 6 * U * 3; i++) begin
            cyc(i % 3 == 0, 1'b1);
            n_cmp++; if (x_a !== m_x) begin n_bad++; $display("FAIL sparse_x cyc=%0d got=%0d exp=%0d", i, x_a, m_x); end
            n_cmp++; if (strobe_a !== m_strobe) begin n_bad++; $display("FAIL sparse_strobe cyc=%0d got=%0b exp=%0b", i, strobe_a, m_strobe); end
            n_cmp++; if (phase_a !== 2'(pos)) begin n_bad++; $display("FAIL sparse_phase cyc=%0d got=%0d exp=%0d", i, phase_a, pos); end
        end
    endtask

    task automatic test_pause();
        logic [14:0] frozen;
        for (int i = 0; i < U && pos != 2; i++) cyc(1'b1, 1'b1);
        n_cmp++; if (phase_a !== 2'd2) begin n_bad++; $display("FAIL pause_setup_phase got=%0d exp=2", phase_a); end
        frozen = model_lfsr();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 2) cyc(1'b0, 1'b0);
            n_cmp++; if (x_a !== 18'sd0 || phase_a !== 2'd0) begin n_bad++; $display("FAIL pause_idle i=%0d got x=%0d ph=%0d exp 0/0", i, x_a, phase_a); end
            n_cmp++; if (u_dut.u_prbs.lfsr !== frozen) begin n_bad++; $display("FAIL pause_lfsr i=%0d got=%h exp=%h", i, u_dut.u_prbs.lfsr, frozen); end
        end
        for (int i = 0; i < 3 * U; i++) begin
            cyc(1'b1, 1'b1);
            n_cmp++; if (x_a !== m_x || bits_a !== m_bits || strobe_a !== m_strobe) begin
                n_bad++; $display("FAIL resume cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, x_a, bits_a, strobe_a, m_x, m_bits, m_strobe);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < U && pos != 3; i++) cyc(1'b1, 1'b1);
        n_cmp++; if (phase_a !== 2'd3) begin n_bad++; $display("FAIL areset_setup_phase got=%0d exp=3", phase_a); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (x_a !== 18'sd0 || phase_a !== 2'd0 || strobe_a !== 1'b0) begin n_bad++; $display("FAIL areset_out got x=%0d ph=%0d st=%0b exp 0/0/0", x_a, phase_a, strobe_a); end
        n_cmp++; if (u_dut.u_prbs.lfsr !== 15'h0001) begin n_bad++; $display("FAIL areset_lfsr got=%h exp=0001", u_dut.u_prbs.lfsr); end
        #1 reset = 1'b0;
        model_reset(15'h0001);
        test_prbs_start("restart");
    endtask

    task automatic test_seed_zero();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (u_dut0.u_prbs.lfsr !== 15'h0001) begin n_bad++; $display("FAIL seed0_lfsr got=%h exp=0001", u_dut0.u_prbs.lfsr); end
        #1 reset = 1'b0;
        model_reset(15'h0001);
        for (int i = 0; i < 8 * U; i++) begin
            cyc(1'b1, 1'b1);
            n_cmp++; if (x_b !== m_x || bits_b !== m_bits || strobe_b !== m_strobe || phase_b !== 2'(pos)) begin
                n_bad++; $display("FAIL seed0 cyc=%0d got=%0d/%0b/%0b/%0d exp=%0d/%0b/%0b/%0d", i, x_b, bits_b, strobe_b, phase_b, m_x, m_bits, m_strobe, pos);
            end
        end
    endtask

    task automatic test_long_run();
        int cnt[4];
        int n_sym, bad_x, bad_set, zero_lfsr, bad_period, tol;
        cnt = '{0, 0, 0, 0};
        n_sym = 0; bad_x = 0; bad_set = 0; zero_lfsr = 0; bad_period = 0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset(15'h0001);
        obs.delete();
        for (int i = 0; i < 16384 * U; i++) begin
            cyc(1'b1, 1'b1);
            if (x_a !== m_x) begin
                if (bad_x < 5) $display("FAIL long_x cyc=%0d got=%0d exp=%0d", i, x_a, m_x);
                bad_x++;
            end
            if (u_dut.u_prbs.lfsr == 15'h0000) zero_lfsr++;
            case (x_a)
                -18'sd98304: if (strobe_a) cnt[0]++;
                -18'sd32768: if (strobe_a) cnt[1]++;
                18'sd32768:  if (strobe_a) cnt[2]++;
                18'sd98304:  if (strobe_a) cnt[3]++;
                18'sd0:      ;
                default:     bad_set++;
            endcase
            if (strobe_a) begin
                obs.push_back(bits_a[1]);
                obs.push_back(bits_a[0]);
                n_sym++;
            end
        end
        n_cmp++; if (bad_x != 0) begin n_bad++; $display("FAIL long_x_total got=%0d errors exp=0", bad_x); end
        n_cmp++; if (bad_set != 0) begin n_bad++; $display("FAIL long_value_set got=%0d illegal exp=0", bad_set); end
        n_cmp++; if (zero_lfsr != 0) begin n_bad++; $display("FAIL long_lfsr_zero got=%0d cycles exp=0", zero_lfsr); end
        n_cmp++; if (n_sym != 16384) begin n_bad++; $display("FAIL long_sym_count got=%0d exp=16384", n_sym); end
        tol = n_sym / 100;
        for (int l = 0; l < 4; l++) begin
            n_cmp++;
            if (cnt[l] < n_sym / 4 - tol || cnt[l] > n_sym / 4 + tol) begin
                n_bad++; $display("FAIL long_hist lvl=%0d got=%0d exp=%0d+-%0d", l, cnt[l], n_sym / 4, tol);
            end
        end
        for (int n = 32767; n < obs.size(); n++) if (obs[n] != obs[n - 32767]) bad_period++;
        n_cmp++; if (bad_period != 0 || obs.size() < 32768) begin n_bad++; $display("FAIL long_period got=%0d breaks in %0d bits exp=0", bad_period, obs.size()); end
    endtask

    initial begin
        reset = 1'b1; samp_en = 1'b0; run = 1'b0;
        test_reset();
        test_prbs_start("start");
        test_sparse_enable();
        test_pause();
        test_async_reset();
        test_seed_zero();
        test_long_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
